alu_issue_wb: RTL and testbench

//  Issue/writeback stage wrapped around the 4-bit combinational ALU (3-bit opcode, operands a/b).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_issue_wb_if.sv | 11 +
 rtl/alu_issue_fifo.sv | 42 ++++
 rtl/alu_issue_wb.sv | 140 ++++++++++++++
 tb/tb_alu_issue_wb.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, FSM states, instruction field helpers.
package alu_pkg;

   localparam int DATA_W      = 4;
   localparam int INSTR_MAX_W = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_DIV = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_NOT = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   // Register fields inside {opcode, rd, ra, rb}, counted from the LSB end.
   localparam int FLD_RB = 0;
   localparam int FLD_RA = 1;
   localparam int FLD_RD = 2;

   typedef enum logic [1:0] {S_IDLE, S_OPRD, S_EXEC, S_WB} state_e;

   function automatic logic [2:0] instr_op(input logic [INSTR_MAX_W-1:0] instr, input int aw);
      return instr[3*aw +: 3];
   endfunction

   function automatic logic [7:0] instr_fld(input logic [INSTR_MAX_W-1:0] instr, input int aw,
                                            input int idx);
      return 8'((instr >> (idx*aw)) & ((16'd1 << aw) - 16'd1));
   endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction issue handshake: the master offers {opcode, rd, ra, rb}, the slave accepts with in_ready.
interface alu_issue_wb_if #(
   parameter int AW = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [2+3*AW:0]   in_instr;

   modport master (output in_valid, in_instr, input in_ready);
   modport slave  (input in_valid, in_instr, output in_ready);
endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one wrap bit to tell full from empty.
module alu_issue_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [PW:0]  wr_q, rd_q;
   logic         do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
   end

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around an external combinational ALU, trapping divide-by-zero.
// Defining ALU_ISSUE_FIFO_EN adds an input FIFO in front of the FSM.
module alu_issue_wb
   import alu_pkg::*;
#(
   parameter int NREGS      = 4,
`ifdef ALU_ISSUE_FIFO_EN
   parameter int FIFO_DEPTH = 4,
`endif
   parameter int DATA_W     = alu_pkg::DATA_W,
   localparam int AW        = $clog2(NREGS),
   localparam int IW        = 3 + 3*AW
)(
   input  logic               clk,
   input  logic               rst_n,
   alu_issue_wb_if.slave      in_if,
   output logic [2:0]         alu_opcode,
   output logic [DATA_W-1:0]  alu_operand_a,
   output logic [DATA_W-1:0]  alu_operand_b,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               rf_we,
   input  logic [AW-1:0]      rf_waddr,
   input  logic [DATA_W-1:0]  rf_wdata,
   input  logic [AW-1:0]      rf_raddr,
   output logic [DATA_W-1:0]  rf_rdata,
   output logic               wb_valid,
   output logic [AW-1:0]      wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               div0_err,
   input  logic               err_clr
);
   state_e            state_q;
   logic [IW-1:0]     instr_q, instr_d;
   logic [DATA_W-1:0] rf_q [NREGS];
   logic [2:0]        opcode_q;
   logic [DATA_W-1:0] opa_q, opb_q, result_q, wb_data_q;
   logic [AW-1:0]     wb_addr_q;
   logic              wb_valid_q, div0_q, div0_d;
   logic              start, wb_we, div0_set;
   logic [2:0]        op_w;
   logic [AW-1:0]     rd_w, ra_w, rb_w;

`ifdef ALU_ISSUE_FIFO_EN
   logic fifo_full, fifo_empty;

   alu_issue_fifo #(.DEPTH(FIFO_DEPTH), .W(IW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (in_if.in_valid),
      .din_i   (in_if.in_instr),
      .pop_i   (start),
      .dout_o  (instr_d),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
   assign in_if.in_ready = !fifo_full;
   assign start          = (state_q == S_IDLE) && !fifo_empty;
`else
   assign in_if.in_ready = (state_q == S_IDLE);
   assign start          = in_if.in_ready && in_if.in_valid;
   assign instr_d        = in_if.in_instr;
`endif

   assign op_w = instr_op(INSTR_MAX_W'(instr_q), AW);
   assign rd_w = AW'(instr_fld(INSTR_MAX_W'(instr_q), AW, FLD_RD));
   assign ra_w = AW'(instr_fld(INSTR_MAX_W'(instr_q), AW, FLD_RA));
   assign rb_w = AW'(instr_fld(INSTR_MAX_W'(instr_q), AW, FLD_RB));

   // The ALU does not guard division; a zero divisor substitutes all-ones and raises the flag.
   assign div0_set = (state_q == S_EXEC) && (opcode_q == OP_DIV) && (opb_q == '0);
   assign div0_d   = div0_set || (div0_q && !err_clr);
   assign wb_we    = (state_q == S_WB);

   // NOTE: every register below uses non-blocking assignment so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         opcode_q   <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         result_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               instr_q <= instr_d;
               state_q <= S_OPRD;
            end
            S_OPRD: begin
               opcode_q <= op_w;
               opa_q    <= rf_q[ra_w];
               opb_q    <= rf_q[rb_w];
               state_q  <= S_EXEC;
            end
            S_EXEC: begin
               result_q <= div0_set ? '1 : alu_result;
               state_q  <= S_WB;
            end
            S_WB: begin
               wb_valid_q <= 1'b1;
               wb_addr_q  <= rd_w;
               wb_data_q  <= result_q;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Writeback wins over a preload to the same entry; a preload elsewhere still lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wb_we && rd_w == AW'(i))          rf_q[i] <= result_q;
            else if (rf_we && rf_waddr == AW'(i)) rf_q[i] <= rf_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div0_q <= 1'b0;
      else        div0_q <= div0_d;
   end

   assign rf_rdata      = rf_q[rf_raddr];
   assign alu_opcode    = opcode_q;
   assign alu_operand_a = opa_q;
   assign alu_operand_b = opb_q;
   assign wb_valid      = wb_valid_q;
   assign wb_addr       = wb_addr_q;
   assign wb_data       = wb_data_q;
   assign div0_err      = div0_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb: directed vectors with hand-computed results, ALU modelled here.
module tb_alu_issue_wb;
   import alu_pkg::*;

`ifdef ALU_ISSUE_FIFO_EN
   localparam int LAT        = 4;
   localparam int BURST_WAIT = 0;
`else
   localparam int LAT        = 3;
   localparam int BURST_WAIT = 3;
`endif

   typedef struct {
      logic [1:0] addr;
      logic [3:0] data;
      int         acc_cyc;
      bit         chk_lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] alu_opcode;
   logic [3:0] alu_operand_a, alu_operand_b, alu_result;
   logic       rf_we;
   logic [1:0] rf_waddr, rf_raddr, wb_addr;
   logic [3:0] rf_wdata, rf_rdata, wb_data;
   logic       wb_valid, div0_err, err_clr;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   w;

   alu_issue_wb_if #(.AW(2)) bus ();

   alu_issue_wb dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_if         (bus),
      .alu_opcode    (alu_opcode),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_result    (alu_result),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .rf_raddr      (rf_raddr),
      .rf_rdata      (rf_rdata),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .div0_err      (div0_err),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External ALU; a zero divisor returns a junk value the stage must discard.
   always_comb begin
      alu_result = 4'h0;
      case (alu_opcode)
         OP_ADD: alu_result = alu_operand_a + alu_operand_b;
         OP_SUB: alu_result = alu_operand_a - alu_operand_b;
         OP_DIV: alu_result = (alu_operand_b == 4'h0) ? 4'h3 : alu_operand_a / alu_operand_b;
         OP_MUL: alu_result = alu_operand_a * alu_operand_b;
         OP_AND: alu_result = alu_operand_a & alu_operand_b;
         OP_OR:  alu_result = alu_operand_a | alu_operand_b;
         OP_NOT: alu_result = ~alu_operand_a;
         OP_XOR: alu_result = alu_operand_a ^ alu_operand_b;
         default: alu_result = 4'h0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid) begin
         if (sb_q.size() == 0) begin
            check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("wb_addr", {30'b0, wb_addr}, {30'b0, mon_e.addr});
            check("wb_data", {28'b0, wb_data}, {28'b0, mon_e.data});
            if (mon_e.chk_lat) check("wb_latency", cyc - mon_e.acc_cyc, LAT);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [3:0] data, input bit exp_wb,
                       input bit lat, input bit hold, output int waited);
      waited = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = {op, rd, ra, rb};
      while (!bus.in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", waited, 0);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      if (exp_wb) sb_q.push_back('{addr: rd, data: data, acc_cyc: cyc, chk_lat: lat});
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) check("drain_timeout", n, 0);
      @(negedge clk);
   endtask

   task automatic preload(input logic [1:0] a, input logic [3:0] d);
      rf_we = 1'b1;
      rf_waddr = a;
      rf_wdata = d;
      @(negedge clk);
      rf_we = 1'b0;
   endtask

   task automatic chk_rf(input string name, input logic [1:0] a, input logic [3:0] d);
      rf_raddr = a;
      #1;
      check(name, {28'b0, rf_rdata}, {28'b0, d});
   endtask

   // Issue an op and drive a preload into the same edge that performs its writeback.
   task automatic op_with_poke(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                               input logic [1:0] rb, input logic [3:0] data,
                               input logic [1:0] pa, input logic [3:0] pd);
      int wt;
      send(op, rd, ra, rb, data, 1'b1, 1'b0, 1'b0, wt);
      repeat (LAT - 1) @(negedge clk);
      rf_we = 1'b1;
      rf_waddr = pa;
      rf_wdata = pd;
      @(negedge clk);
      rf_we = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      rf_we = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      rf_raddr = '0;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_in_ready", {31'b0, bus.in_ready}, 1);
      check("rst_wb_valid", {31'b0, wb_valid}, 0);
      check("rst_wb_addr", {30'b0, wb_addr}, 0);
      check("rst_wb_data", {28'b0, wb_data}, 0);
      check("rst_div0", {31'b0, div0_err}, 0);
      check("rst_alu_op", {29'b0, alu_opcode}, 0);
      check("rst_alu_a", {28'b0, alu_operand_a}, 0);
      check("rst_alu_b", {28'b0, alu_operand_b}, 0);
      for (int i = 0; i < 4; i++) chk_rf("rst_rf", 2'(i), 4'h0);

      // Same-cycle preload read returns the old value
      @(negedge clk);
      rf_raddr = 2'd1;
      rf_we = 1'b1;
      rf_waddr = 2'd1;
      rf_wdata = 4'h3;
      #1 check("rf_read_old", {28'b0, rf_rdata}, 0);
      @(negedge clk);
      rf_we = 1'b0;
      #1 check("rf_read_new", {28'b0, rf_rdata}, 3);
      @(negedge clk);
      preload(2'd2, 4'h5);

      send(OP_ADD, 2'd0, 2'd1, 2'd2, 4'h8, 1'b1, 1'b1, 1'b0, w);
      drain();
      chk_rf("add_rf0", 2'd0, 4'h8);

      // Wrapping add and subtract
      preload(2'd1, 4'h9);
      preload(2'd2, 4'h9);
      send(OP_ADD, 2'd0, 2'd1, 2'd2, 4'h2, 1'b1, 1'b1, 1'b0, w);
      drain();
      preload(2'd1, 4'h2);
      preload(2'd2, 4'h5);
      send(OP_SUB, 2'd0, 2'd1, 2'd2, 4'hD, 1'b1, 1'b1, 1'b0, w);
      drain();
      chk_rf("sub_rf0", 2'd0, 4'hD);

      // Divide by zero (r3 still 0): all-ones result, sticky flag, clear
      send(OP_DIV, 2'd2, 2'd1, 2'd3, 4'hF, 1'b1, 1'b0, 1'b0, w);
      drain();
      check("div0_set", {31'b0, div0_err}, 1);
      repeat (2) @(negedge clk);
      check("div0_sticky", {31'b0, div0_err}, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("div0_clr", {31'b0, div0_err}, 0);

      // Clear coinciding with the set edge: set wins
      send(OP_DIV, 2'd0, 2'd1, 2'd3, 4'hF, 1'b1, 1'b0, 1'b0, w);
      repeat (LAT - 2) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("div0_set_wins", {31'b0, div0_err}, 1);
      drain();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      send(OP_DIV, 2'd3, 2'd2, 2'd1, 4'h7, 1'b1, 1'b0, 1'b0, w);
      drain();
      check("div_ok_no_err", {31'b0, div0_err}, 0);

      // Dependent back-to-back burst: r0=F r1=2 r2=F r3=7
      send(OP_XOR, 2'd0, 2'd1, 2'd3, 4'h5, 1'b1, 1'b0, 1'b1, w);
      send(OP_NOT, 2'd1, 2'd0, 2'd0, 4'hA, 1'b1, 1'b0, 1'b1, w);
      check("burst_wait2", w, BURST_WAIT);
      send(OP_XOR, 2'd2, 2'd1, 2'd3, 4'hD, 1'b1, 1'b0, 1'b0, w);
      check("burst_wait3", w, BURST_WAIT);
      drain();
      chk_rf("chain_r0", 2'd0, 4'h5);
      chk_rf("chain_r1", 2'd1, 4'hA);
      chk_rf("chain_r2", 2'd2, 4'hD);

      // Writeback vs preload in the same edge
      op_with_poke(OP_ADD, 2'd0, 2'd1, 2'd3, 4'h1, 2'd0, 4'h6);
      chk_rf("wb_beats_poke", 2'd0, 4'h1);
      op_with_poke(OP_ADD, 2'd1, 2'd2, 2'd3, 4'h4, 2'd3, 4'h2);
      chk_rf("poke_other_r3", 2'd3, 4'h2);
      chk_rf("poke_other_r1", 2'd1, 4'h4);
      send(OP_MUL, 2'd2, 2'd1, 2'd3, 4'h8, 1'b1, 1'b0, 1'b0, w);
      drain();
      check("alu_hold_op", {29'b0, alu_opcode}, {29'b0, OP_MUL});

      // Reset while an op is in EXEC: no writeback, RF cleared
      send(OP_ADD, 2'd0, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0, 1'b0, w);
      repeat (LAT - 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) chk_rf("rst2_rf", 2'(i), 4'h0);
      check("rst2_alu_op", {29'b0, alu_opcode}, 0);
      check("rst2_in_ready", {31'b0, bus.in_ready}, 1);

`ifdef ALU_ISSUE_FIFO_EN
      // Back-to-back pushes fill the FIFO; the sixth waits for a pop
      preload(2'd1, 4'h5);
      for (int i = 0; i < 6; i++) begin
         send(OP_OR, 2'd2, 2'd1, 2'd1, 4'h5, 1'b1, 1'b0, (i < 5), w);
         if (i < 5) check("fifo_push_nowait", w, 0);
         else       check("fifo_sixth_stalls", {31'b0, (w > 0)}, 1);
      end
      drain();
`endif

      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
